// File: rtl/mem_pkg.sv
// Shared definitions for the latency data memory.
// Funct3 encodings, FSM states and the alignment helper.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  // funct3[1:0] gives the access size for loads and stores alike
  function automatic logic misaligned(
    input logic [2:0] funct3,
    input logic [1:0] lane
  );
    logic half, word;
    half = (funct3[1:0] == 2'b01);
    word = (funct3[1:0] == 2'b10);
    return (half && lane[0]) || (word && (lane != 2'b00));
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Sub-word lane steering: load extension, store merge and
// access legality for one request against one memory word.
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int MEM_DEPTH = 16384
) (
  input  logic        write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] new_word,
  output logic        error
);

  logic [1:0]  lane;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        bad_f3;
  logic        out_of_range;

  assign lane     = addr[1:0];
  assign byte_sel = old_word[{lane, 3'b000} +: 8];
  assign half_sel = addr[1] ? old_word[31:16] : old_word[15:0];

  always_comb begin
    load_data = '0;
    unique case (1'b1)
      funct3 == F3_B:  load_data = {{24{byte_sel[7]}}, byte_sel};
      funct3 == F3_BU: load_data = {24'h0, byte_sel};
      funct3 == F3_H:  load_data = {{16{half_sel[15]}}, half_sel};
      funct3 == F3_HU: load_data = {16'h0, half_sel};
      funct3 == F3_W:  load_data = old_word;
      default:         load_data = '0;
    endcase
  end

  always_comb begin
    new_word = old_word;
    unique case (1'b1)
      funct3 == F3_B: new_word[{lane, 3'b000} +: 8] = wdata[7:0];
      funct3 == F3_H: begin
        if (addr[1]) new_word[31:16] = wdata[15:0];
        else         new_word[15:0]  = wdata[15:0];
      end
      funct3 == F3_W: new_word = wdata;
      default:        new_word = old_word;
    endcase
  end

  always_comb begin
    if (write) bad_f3 = funct3[2] || (funct3 == 3'b011);
    else       bad_f3 = (funct3 == 3'b011) || (funct3 == 3'b110)
                     || (funct3 == 3'b111);
    out_of_range = {2'b00, addr[31:2]} >= 32'(MEM_DEPTH);
    error = bad_f3 || misaligned(funct3, lane) || out_of_range;
  end

endmodule

// File: rtl/lat_data_memory.sv
// Configurable-latency data memory with a valid/ready request side
// and a one-cycle response strobe; sub-word RMW done internally.
module lat_data_memory
  import mem_pkg::*;
#(
  parameter int    MEM_DEPTH = 16384,
  parameter int    LATENCY   = 4,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error
);

  localparam int IW   = $clog2(MEM_DEPTH);
  localparam bit FAST = (LATENCY == 1);

  logic [31:0] mem [MEM_DEPTH];

  state_t      state;
  logic [7:0]  count;
  logic        write_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic        a_write;
  logic [2:0]  a_funct3;
  logic [31:0] a_addr;
  logic [31:0] a_wdata;
  logic [IW-1:0] idx;
  logic [31:0] old_word;
  logic [31:0] load_data;
  logic [31:0] new_word;
  logic        error;
  logic        commit;

  // Single-cycle builds commit at acceptance, straight off the request
  assign a_write  = FAST ? req_write  : write_q;
  assign a_funct3 = FAST ? req_funct3 : funct3_q;
  assign a_addr   = FAST ? req_addr   : addr_q;
  assign a_wdata  = FAST ? req_wdata  : wdata_q;
  assign idx      = a_addr[IW+1:2];
  assign old_word = mem[idx];

  assign req_ready = (state == IDLE) && !reset;

  assign commit = (FAST && state == IDLE && req_valid)
               || (state == WAIT && count == 8'd1);

  mem_lane_align #(
    .MEM_DEPTH(MEM_DEPTH)
  ) u_align (
    .write    (a_write),
    .funct3   (a_funct3),
    .addr     (a_addr),
    .old_word (old_word),
    .wdata    (a_wdata),
    .load_data(load_data),
    .new_word (new_word),
    .error    (error)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_error <= 1'b0;
      for (int i = 0; i < MEM_DEPTH; i++)
        mem[i] <= '0;
    end else begin
      resp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            write_q  <= req_write;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            if (FAST) begin
              state <= DONE;
            end else begin
              count <= 8'(LATENCY - 1);
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          count <= count - 8'd1;
          if (count == 8'd1) state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
      if (commit) begin
        resp_valid <= 1'b1;
        resp_error <= error;
        resp_rdata <= (error || a_write) ? '0 : load_data;
        if (a_write && !error) mem[idx] <= new_word;
      end
    end
  end

endmodule

// File: tb/tb_lat_data_memory.sv
// Directed bench: byte-addressed reference memory plus literal checks,
// one LATENCY=4 instance and one LATENCY=1 instance.
module tb_lat_data_memory;

  localparam int DEPTH = 16384;
  localparam int LAT   = 4;

  typedef struct {
    int          due;
    logic        w;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] d;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;

  logic        v1 = 1'b0;
  logic        w1 = 1'b0;
  logic [2:0]  f31 = 3'b0;
  logic [31:0] a1 = '0;
  logic [31:0] d1 = '0;
  logic        ready1;
  logic        rv1;
  logic [31:0] rd1;
  logic        re1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  txn_t q[$];
  logic [7:0] bmem [logic [31:0]];

  lat_data_memory #(.MEM_DEPTH(DEPTH), .LATENCY(LAT), .INIT_FILE("")) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_error(resp_error)
  );

  lat_data_memory #(.MEM_DEPTH(DEPTH), .LATENCY(1), .INIT_FILE("")) dut1 (
    .clk(clk), .reset(reset),
    .req_valid(v1), .req_ready(ready1),
    .req_write(w1), .req_funct3(f31),
    .req_addr(a1), .req_wdata(d1),
    .resp_valid(rv1), .resp_rdata(rd1),
    .resp_error(re1)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    return bmem.exists(a) ? bmem[a] : 8'h00;
  endfunction

  // Reference model for the LATENCY=4 instance
  initial forever begin
    txn_t t;
    int n;
    logic e;
    logic [31:0] ed;
    @(negedge clk);
    if (reset) begin
      chk("ready_in_reset", {31'b0, req_ready}, 32'd0);
      q.delete();
      bmem.delete();
    end else begin
      chk("ready", {31'b0, req_ready}, {31'b0, q.size() == 0});
      if (q.size() > 0 && q[0].due == cyc) begin
        chk("resp_valid", {31'b0, resp_valid}, 32'd1);
        t = q.pop_front();
        n = (t.f3[1:0] == 2'b00) ? 1 : (t.f3[1:0] == 2'b01) ? 2 : 4;
        e = (t.f3[1:0] == 2'b11) || (t.f3[2] && (t.w || t.f3[1]))
          || ((t.a % n) != 0) || ((t.a >> 2) >= DEPTH);
        ed = '0;
        if (!e && t.w) begin
          for (int i = 0; i < n; i++) bmem[t.a + i] = t.d[8*i +: 8];
        end else if (!e) begin
          for (int i = 0; i < n; i++) ed[8*i +: 8] = rd_byte(t.a + i);
          if (!t.f3[2] && n < 4 && ed[8*n-1])
            ed = ed | ~((32'd1 << (8*n)) - 32'd1);
        end
        chk("resp_rdata", resp_rdata, ed);
        chk("resp_error", {31'b0, resp_error}, {31'b0, e});
      end else begin
        chk("resp_valid", {31'b0, resp_valid}, 32'd0);
      end
      if (req_valid && req_ready) begin
        t.due = cyc + LAT;
        t.w = req_write;
        t.f3 = req_funct3;
        t.a = req_addr;
        t.d = req_wdata;
        q.push_back(t);
      end
    end
  end

  logic [31:0] exp1 [4] = '{32'h0, 32'hA5A5A5A5, 32'hFFFFFFA5, 32'h0000A5A5};

  // Timing and data check for the LATENCY=1 instance
  initial begin
    int due1;
    int k1;
    due1 = -1;
    k1 = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        due1 = -1;
      end else begin
        chk("l1_ready", {31'b0, ready1}, {31'b0, cyc != due1});
        chk("l1_valid", {31'b0, rv1}, {31'b0, cyc == due1});
        if (cyc == due1 && k1 < 4) begin
          chk("l1_rdata", rd1, exp1[k1]);
          chk("l1_error", {31'b0, re1}, 32'd0);
          k1++;
        end
        if (v1 && ready1) due1 = cyc + 1;
      end
    end
  end

  task automatic xact(input logic w, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] er, input logic ee,
                      input string name);
    int n;
    @(posedge clk);
    #1;
    req_write = w;
    req_funct3 = f3;
    req_addr = a;
    req_wdata = d;
    req_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 50);
    if (!req_ready) begin
      errors++;
      $display("FAIL %s_accept: ready never seen", name);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resp_valid && n < 50);
    chk({name, "_lat"}, n, LAT);
    chk({name, "_rdata"}, resp_rdata, er);
    chk({name, "_err"}, {31'b0, resp_error}, {31'b0, ee});
  endtask

  initial begin
    int n;
    int acc [4];
    logic [31:0] aa [4] = '{32'h10, 32'h10, 32'h10, 32'h12};
    logic [2:0]  ff [4] = '{3'b010, 3'b010, 3'b000, 3'b101};
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_error", {31'b0, resp_error}, 32'd0);
    chk("rst_ready", {31'b0, req_ready}, 32'd1);

    xact(0, 3'b010, 32'h0,     32'h0,        32'h0,        0, "lw0");
    xact(1, 3'b010, 32'h100,   32'hDEADBEEF, 32'h0,        0, "sw");
    xact(1, 3'b000, 32'h101,   32'h0000007F, 32'h0,        0, "sb");
    xact(0, 3'b010, 32'h100,   32'h0,        32'hDEAD7FEF, 0, "lw_m");
    xact(0, 3'b000, 32'h103,   32'h0,        32'hFFFFFFDE, 0, "lb");
    xact(0, 3'b100, 32'h103,   32'h0,        32'h000000DE, 0, "lbu");
    xact(0, 3'b001, 32'h102,   32'h0,        32'hFFFFDEAD, 0, "lh");
    xact(0, 3'b101, 32'h100,   32'h0,        32'h00007FEF, 0, "lhu");
    xact(1, 3'b010, 32'h102,   32'h11111111, 32'h0,        1, "sw_mis");
    xact(0, 3'b001, 32'h101,   32'h0,        32'h0,        1, "lh_mis");
    xact(0, 3'b010, 32'h100,   32'h0,        32'hDEAD7FEF, 0, "lw_keep");
    xact(0, 3'b010, 32'h10000, 32'h0,        32'h0,        1, "lw_oob");
    xact(0, 3'b011, 32'h0,     32'h0,        32'h0,        1, "ld_f3");
    xact(1, 3'b100, 32'h100,   32'h0,        32'h0,        1, "st_f3");
    xact(1, 3'b001, 32'h106,   32'h1234BEEF, 32'h0,        0, "sh");
    xact(0, 3'b010, 32'h104,   32'h0,        32'hBEEF0000, 0, "lw_sh");

    // Abort a store with reset while it waits
    @(posedge clk);
    #1;
    req_write = 1'b1;
    req_funct3 = 3'b010;
    req_addr = 32'h200;
    req_wdata = 32'h12345678;
    req_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 50);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (resp_valid) n++;
    end
    chk("abort_no_resp", n, 0);
    xact(0, 3'b010, 32'h200, 32'h0, 32'h0, 0, "lw_abort");
    xact(0, 3'b010, 32'h100, 32'h0, 32'h0, 0, "lw_cleared");

    // LATENCY=1 instance with req_valid held high
    @(posedge clk);
    #1;
    v1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w1 = (i == 0);
      f31 = ff[i];
      a1 = aa[i];
      d1 = 32'hA5A5A5A5;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!ready1 && n < 20);
      acc[i] = cyc + 1;
      @(posedge clk);
      #1;
    end
    v1 = 1'b0;
    for (int i = 1; i < 4; i++) chk("l1_spacing", acc[i] - acc[i-1], 2);
    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
